// File: rtl/rx_ring_pkg.sv
// Shared types and header field positions for the RX packet ring writer.
package rx_ring_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FLUSH,
    HDR
  } rx_state_e;

  localparam int unsigned HDR_VALID   = 31;
  localparam int unsigned HDR_OVF     = 21;
  localparam int unsigned HDR_ERR_LSB = 16;
  localparam int unsigned HDR_LEN_MSB = 15;

  function automatic logic [31:0] pack_header(input logic        ovf,
                                              input logic [4:0]  err,
                                              input logic [15:0] len);
    logic [31:0] h;
    h                       = '0;
    h[HDR_VALID]            = 1'b1;
    h[HDR_OVF]              = ovf;
    h[HDR_ERR_LSB +: 5]     = err;
    h[HDR_LEN_MSB:0]        = len;
    return h;
  endfunction

endpackage

// File: rtl/rx_word_packer.sv
// Little-endian byte-to-word packer: accumulates bytes, reports lane fill,
// byteenable for the (possibly partial) word and a word-complete flag.
module rx_word_packer #(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            push_i,
  input  logic            done_i,
  input  logic [7:0]      byte_i,
  output logic [DW-1:0]   word_o,
  output logic [DW/8-1:0] be_o,
  output logic            full_o,
  output logic            any_o
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned LW = $clog2(NB);

  logic [DW-1:0] acc_q, acc_d, base_acc;
  logic [LW-1:0] lane_q, lane_d, base_lane;
  logic [LW:0]   fill;

  // start_i discards any leftover bytes so the sop byte lands in lane 0
  always_comb begin
    base_acc  = start_i ? '0 : acc_q;
    base_lane = start_i ? '0 : lane_q;
    word_o    = base_acc;
    for (int unsigned i = 0; i < NB; i++) begin
      if (push_i && base_lane == LW'(i)) word_o[i*8 +: 8] = byte_i;
    end
    fill   = {1'b0, base_lane} + (LW+1)'(push_i);
    full_o = (fill == (LW+1)'(NB));
    any_o  = (fill != '0);
    for (int unsigned i = 0; i < NB; i++) begin
      be_o[i] = ((LW+1)'(i) < fill);
    end
    if (full_o || done_i) begin
      acc_d  = '0;
      lane_d = '0;
    end else begin
      acc_d  = word_o;
      lane_d = fill[LW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      lane_q <= '0;
    end else begin
      acc_q  <= acc_d;
      lane_q <= lane_d;
    end
  end

endmodule

// File: rtl/rx_packet_ring_writer.sv
// Writes byte-wide Avalon-ST packets into a ring of fixed-size RAM slots with a
// header word per slot. Optional macro RX_PKT_ERR_DROP_EN drops errored packets.
module rx_packet_ring_writer
  import rx_ring_pkg::*;
#(
  parameter int unsigned RAM_DW  = 32,
  parameter int unsigned RAM_AW  = 10,
  parameter int unsigned SLOT_AW = 8
) (
  input  logic                        clk_original,
  input  logic                        rst,
  input  logic [7:0]                  ff_rx_data,
  input  logic                        ff_rx_sop,
  input  logic                        ff_rx_eop,
  input  logic                        ff_rx_dval,
  input  logic [4:0]                  rx_err,
  output logic                        ff_rx_rdy,
  output logic [RAM_AW-1:0]           ram_addr,
  output logic                        ram_chipselect,
  output logic                        ram_write,
  output logic [RAM_DW-1:0]           ram_writedata,
  output logic [RAM_DW/8-1:0]         ram_byteenable,
  input  logic                        slot_release,
  output logic                        pkt_done,
  output logic [RAM_AW-SLOT_AW-1:0]   pkt_slot,
  output logic [RAM_AW-SLOT_AW:0]     slots_used,
  output logic                        ring_full
);

  localparam int unsigned SW  = RAM_AW - SLOT_AW;
  localparam int unsigned NS  = 1 << SW;
  localparam int unsigned NB  = RAM_DW / 8;
  localparam logic [15:0] CAP = 16'(((1 << SLOT_AW) - 1) * NB);

`ifdef RX_PKT_ERR_DROP_EN
  localparam logic ERR_DROP = 1'b1;
`else
  localparam logic ERR_DROP = 1'b0;
`endif

  rx_state_e state_q, state_d;

  logic               rdy_q, rdy_d;
  logic [SLOT_AW-1:0] wp_q, wp_d, wp_cur;
  logic [15:0]        len_q, len_d;
  logic               ovf_q, ovf_d;
  logic [4:0]         err_q, err_d;
  logic [SW-1:0]      wslot_q, wslot_d;
  logic [SW:0]        used_q, used_d;
  logic               full_q, full_d;
  logic               wr_q, wr_d;
  logic [RAM_AW-1:0]  addr_q, addr_d;
  logic [RAM_DW-1:0]  data_q, data_d;
  logic [NB-1:0]      be_q, be_d;
  logic               done_q, done_d;
  logic [SW-1:0]      pslot_q, pslot_d;

  logic beat, start, store, push, eop_beat, commit, release_ok;
  logic [RAM_DW-1:0] pk_word;
  logic [NB-1:0]     pk_be;
  logic              pk_full, pk_any;

  // sop restarts the packet in both IDLE and RECV; stray non-sop beats in IDLE are dropped
  always_comb begin
    beat       = ff_rx_dval & rdy_q;
    start      = beat & ff_rx_sop & ((state_q == IDLE) | (state_q == RECV));
    store      = start | (beat & (state_q == RECV));
    push       = store & (start | (len_q != CAP));
    eop_beat   = store & ff_rx_eop;
    wp_cur     = start ? SLOT_AW'(1) : wp_q;
    commit     = (state_q == HDR);
    release_ok = slot_release & (used_q != '0);
  end

  rx_word_packer #(.DW(RAM_DW)) u_packer (
    .clk     (clk_original),
    .rst     (rst),
    .start_i (start),
    .push_i  (push),
    .done_i  (eop_beat),
    .byte_i  (ff_rx_data),
    .word_o  (pk_word),
    .be_o    (pk_be),
    .full_o  (pk_full),
    .any_o   (pk_any)
  );

  always_ff @(posedge clk_original or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = eop_beat ? FLUSH : RECV;
      RECV:    if (eop_beat) state_d = FLUSH;
      FLUSH:   state_d = (ERR_DROP && err_q != '0) ? IDLE : HDR;
      HDR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The partial last word is registered on the eop beat itself, so it appears
  // on the bus while the FSM sits in FLUSH; the header follows from FLUSH.
  always_comb begin
    wr_d    = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    be_d    = '0;
    done_d  = 1'b0;
    pslot_d = pslot_q;
    if (push && (pk_full || (eop_beat && pk_any))) begin
      wr_d   = 1'b1;
      addr_d = {wslot_q, wp_cur};
      data_d = pk_word;
      be_d   = pk_be;
    end
    if (state_q == FLUSH && state_d == HDR) begin
      wr_d   = 1'b1;
      addr_d = {wslot_q, SLOT_AW'(0)};
      data_d = RAM_DW'(pack_header(ovf_q, err_q, len_q));
      be_d   = '1;
    end
    if (commit) begin
      done_d  = 1'b1;
      pslot_d = wslot_q;
    end
    used_d = used_q + (SW+1)'(commit) - (SW+1)'(release_ok);
    full_d = (used_d == (SW+1)'(NS));
    unique case (state_d)
      IDLE:    rdy_d = ~full_d;
      RECV:    rdy_d = 1'b1;
      default: rdy_d = 1'b0;
    endcase
  end

  always_comb begin
    wp_d    = wp_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    wslot_d = wslot_q;
    if (store) begin
      wp_d  = (push && pk_full) ? wp_cur + 1'b1 : wp_cur;
      len_d = start ? 16'(push) : len_q + 16'(push);
      ovf_d = start ? 1'b0 : (ovf_q | ~push);
      if (eop_beat)   err_d = rx_err;
      else if (start) err_d = '0;
    end
    if (commit) wslot_d = wslot_q + 1'b1;
  end

  always_ff @(posedge clk_original or posedge rst) begin
    if (rst) begin
      rdy_q   <= 1'b0;
      wp_q    <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= '0;
      wslot_q <= '0;
      used_q  <= '0;
      full_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      done_q  <= 1'b0;
      pslot_q <= '0;
    end else begin
      rdy_q   <= rdy_d;
      wp_q    <= wp_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      wslot_q <= wslot_d;
      used_q  <= used_d;
      full_q  <= full_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      done_q  <= done_d;
      pslot_q <= pslot_d;
    end
  end

  assign ff_rx_rdy      = rdy_q;
  assign ram_addr       = addr_q;
  assign ram_chipselect = wr_q;
  assign ram_write      = wr_q;
  assign ram_writedata  = data_q;
  assign ram_byteenable = be_q;
  assign pkt_done       = done_q;
  assign pkt_slot       = pslot_q;
  assign slots_used     = used_q;
  assign ring_full      = full_q;

endmodule

// File: tb/tb_rx_packet_ring_writer.sv
// Directed testbench for rx_packet_ring_writer (default parameters: NS=4, CAP=1020).
module tb_rx_packet_ring_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ff_rx_data = '0;
  logic        ff_rx_sop = 1'b0;
  logic        ff_rx_eop = 1'b0;
  logic        ff_rx_dval = 1'b0;
  logic [4:0]  rx_err = '0;
  logic        ff_rx_rdy;
  logic [9:0]  ram_addr;
  logic        ram_chipselect;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic [3:0]  ram_byteenable;
  logic        slot_release = 1'b0;
  logic        pkt_done;
  logic [1:0]  pkt_slot;
  logic [2:0]  slots_used;
  logic        ring_full;

  always #5 clk = ~clk;

  rx_packet_ring_writer #(.RAM_DW(32), .RAM_AW(10), .SLOT_AW(8)) dut (
    .clk_original   (clk),
    .rst            (rst),
    .ff_rx_data     (ff_rx_data),
    .ff_rx_sop      (ff_rx_sop),
    .ff_rx_eop      (ff_rx_eop),
    .ff_rx_dval     (ff_rx_dval),
    .rx_err         (rx_err),
    .ff_rx_rdy      (ff_rx_rdy),
    .ram_addr       (ram_addr),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_writedata  (ram_writedata),
    .ram_byteenable (ram_byteenable),
    .slot_release   (slot_release),
    .pkt_done       (pkt_done),
    .pkt_slot       (pkt_slot),
    .slots_used     (slots_used),
    .ring_full      (ring_full)
  );

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    int unsigned cyc;
  } wr_t;

  wr_t         wlog[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned done_cnt = 0;
  int unsigned done_cyc = 0;
  int unsigned last_cyc = 0;
  logic [1:0]  last_slot = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    check_eq("cs_eq_write", ram_chipselect, ram_write);
    if (ram_write) wlog.push_back('{ram_addr, ram_writedata, ram_byteenable, cyc});
    if (pkt_done) begin
      done_cnt++;
      last_slot = pkt_slot;
      done_cyc  = cyc;
    end
  end

  task automatic check_wr(input string tag, input int unsigned idx,
                          input logic [9:0] addr, input logic [31:0] data, input logic [3:0] be);
    check_eq({tag, "_present"}, idx < wlog.size(), 1'b1);
    if (idx < wlog.size()) begin
      check_eq({tag, "_addr"}, wlog[idx].addr, addr);
      check_eq({tag, "_data"}, wlog[idx].data, data);
      check_eq({tag, "_be"},   wlog[idx].be,   be);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    ff_rx_dval = 1'b0; ff_rx_sop = 1'b0; ff_rx_eop = 1'b0; rx_err = '0; slot_release = 1'b0;
    repeat (2) @(negedge clk);
    check_eq({tag, "_rst_rdy"},   ff_rx_rdy,      0);
    check_eq({tag, "_rst_addr"},  ram_addr,       0);
    check_eq({tag, "_rst_wr"},    ram_write,      0);
    check_eq({tag, "_rst_cs"},    ram_chipselect, 0);
    check_eq({tag, "_rst_data"},  ram_writedata,  0);
    check_eq({tag, "_rst_be"},    ram_byteenable, 0);
    check_eq({tag, "_rst_done"},  pkt_done,       0);
    check_eq({tag, "_rst_slot"},  pkt_slot,       0);
    check_eq({tag, "_rst_used"},  slots_used,     0);
    check_eq({tag, "_rst_full"},  ring_full,      0);
    rst = 1'b0;
    @(negedge clk);
    check_eq({tag, "_rdy_after_rst"}, ff_rx_rdy, 1);
  endtask

  task automatic send_beat(input logic [7:0] d, input logic s, input logic e, input logic [4:0] er);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!ff_rx_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ff_rx_rdy) begin
      check_eq("rdy_timeout", ff_rx_rdy, 1);
    end else begin
      ff_rx_data = d; ff_rx_sop = s; ff_rx_eop = e; rx_err = er; ff_rx_dval = 1'b1;
      @(posedge clk);
      #1;
      last_cyc = cyc;
      ff_rx_dval = 1'b0; ff_rx_sop = 1'b0; ff_rx_eop = 1'b0; rx_err = '0;
    end
  endtask

  // byte n (1-based) of every packet carries value n mod 256
  task automatic send_pkt(input int unsigned len, input logic [4:0] er, input logic rel_at_hdr);
    for (int unsigned i = 0; i < len; i++) begin
      send_beat(8'((i + 1) & 32'hFF), i == 0, i == len - 1, (i == len - 1) ? er : 5'd0);
    end
    if (rel_at_hdr) begin
      @(negedge clk);
      @(negedge clk);
      slot_release = 1'b1;
      @(negedge clk);
      slot_release = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_release();
    @(negedge clk);
    slot_release = 1'b1;
    @(negedge clk);
    slot_release = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d0;

    // 6-byte packet into slot 0, preceded by a stray non-sop beat
    do_reset("t1");
    wlog.delete();
    d0 = done_cnt;
    send_beat(8'hAA, 1'b0, 1'b0, 5'd0);
    send_pkt(6, 5'd0, 1'b0);
    check_eq("t1_nwr", wlog.size(), 3);
    check_wr("t1_w0",  0, 10'd1, 32'h04030201, 4'hF);
    check_wr("t1_w1",  1, 10'd2, 32'h00000605, 4'h3);
    check_wr("t1_hdr", 2, 10'd0, 32'h80000006, 4'hF);
    check_eq("t1_done", done_cnt - d0, 1);
    check_eq("t1_slot", last_slot, 0);
    check_eq("t1_used", slots_used, 1);
    if (wlog.size() >= 3) begin
      check_eq("t1_flush_lat", wlog[1].cyc, last_cyc);
      check_eq("t1_hdr_lat",   wlog[2].cyc, last_cyc + 1);
    end
    check_eq("t1_done_lat", done_cyc, last_cyc + 2);

    // fill the ring with four 64-byte packets, then free one slot
    do_reset("t2");
    for (int unsigned p = 0; p < 4; p++) begin
      wlog.delete();
      send_pkt(64, 5'd0, 1'b0);
      check_eq("t2_slot", last_slot, 2'(p));
    end
    check_eq("t2_nwr", wlog.size(), 17);
    check_wr("t2_last", 15, 10'd784, 32'h403F3E3D, 4'hF);
    check_wr("t2_hdr",  16, 10'd768, 32'h80000040, 4'hF);
    check_eq("t2_used_full", slots_used, 4);
    check_eq("t2_ring_full", ring_full, 1);
    check_eq("t2_rdy_full", ff_rx_rdy, 0);
    pulse_release();
    check_eq("t2_used_rel", slots_used, 3);
    check_eq("t2_full_rel", ring_full, 0);
    check_eq("t2_rdy_rel", ff_rx_rdy, 1);
    wlog.delete();
    send_pkt(6, 5'd0, 1'b0);
    check_wr("t2_p5_w0",  0, 10'd1, 32'h04030201, 4'hF);
    check_wr("t2_p5_hdr", 2, 10'd0, 32'h80000006, 4'hF);
    check_eq("t2_p5_slot", last_slot, 0);
    check_eq("t2_p5_full", ring_full, 1);

    // oversize packet saturates at CAP and sets overflow
    do_reset("t3");
    wlog.delete();
    send_pkt(1100, 5'd0, 1'b0);
    check_eq("t3_nwr", wlog.size(), 256);
    check_wr("t3_last", 254, 10'd255, 32'hFCFBFAF9, 4'hF);
    check_wr("t3_hdr",  255, 10'd0,   32'h802003FC, 4'hF);

    // errored 8-byte packet into slot 1
    wlog.delete();
    d0 = done_cnt;
    send_pkt(8, 5'b00010, 1'b0);
    check_wr("t4_w0", 0, 10'd257, 32'h04030201, 4'hF);
    check_wr("t4_w1", 1, 10'd258, 32'h08070605, 4'hF);
`ifdef RX_PKT_ERR_DROP_EN
    check_eq("t4_nwr",  wlog.size(), 2);
    check_eq("t4_done", done_cnt - d0, 0);
    check_eq("t4_used", slots_used, 1);
`else
    check_eq("t4_nwr",  wlog.size(), 3);
    check_wr("t4_hdr", 2, 10'd256, 32'h80020008, 4'hF);
    check_eq("t4_done", done_cnt - d0, 1);
    check_eq("t4_slot", last_slot, 1);
    check_eq("t4_used", slots_used, 2);
`endif

    // reset in the middle of a packet into slot 1
    do_reset("t5a");
    send_pkt(6, 5'd0, 1'b0);
    check_eq("t5_used_pre", slots_used, 1);
    send_beat(8'h11, 1'b1, 1'b0, 5'd0);
    send_beat(8'h22, 1'b0, 1'b0, 5'd0);
    send_beat(8'h33, 1'b0, 1'b0, 5'd0);
    do_reset("t5b");
    wlog.delete();
    send_pkt(6, 5'd0, 1'b0);
    check_eq("t5_slot", last_slot, 0);
    check_wr("t5_hdr", 2, 10'd0, 32'h80000006, 4'hF);
    check_eq("t5_used", slots_used, 1);

    // commit coincident with release at slots_used == 2
    do_reset("t6");
    send_pkt(6, 5'd0, 1'b0);
    send_pkt(6, 5'd0, 1'b0);
    check_eq("t6_used_pre", slots_used, 2);
    d0 = done_cnt;
    send_pkt(6, 5'd0, 1'b1);
    check_eq("t6_done", done_cnt - d0, 1);
    check_eq("t6_slot", last_slot, 2);
    check_eq("t6_used", slots_used, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
